// File: rtl/ram_program_loader_if.sv
// Word stream into the RAM program loader: valid/ready handshake carrying one N-bit word.
interface ram_program_loader_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] in_dat;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_dat, output in_valid, input in_ready);
  modport slave  (input in_dat, input in_valid, output in_ready);
endinterface

// File: rtl/ram_program_loader.sv
// Streams words from a valid/ready source into consecutive RAM addresses from 0,
// driving the RAM's manual-programming inputs (prog / sw_mar / sw_dat / ri).
module ram_program_loader #(
  parameter int unsigned N = 8,
  parameter int unsigned A = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [A:0]           len,
  ram_program_loader_if.slave  in_if,
  input  logic                 abort,
  output logic                 prog,
  output logic [A-1:0]         sw_mar,
  output logic [N-1:0]         sw_dat,
  output logic                 ri,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int unsigned CW    = A + 1;
  localparam int unsigned DEPTH = 1 << A;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [A-1:0]  mar_d;
  logic [N-1:0]  dat_d;
  logic          prog_d, ri_d, busy_d, done_d, aborted_d;
  logic          in_ready_q, in_ready_d;

  assign in_if.in_ready = in_ready_q;

  // State and all outputs registered together; next values come from the decode below.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      sw_mar     <= '0;
      sw_dat     <= '0;
      prog       <= 1'b0;
      ri         <= 1'b0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sw_mar     <= mar_d;
      sw_dat     <= dat_d;
      prog       <= prog_d;
      ri         <= ri_d;
      in_ready_q <= in_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
    end
  end

  // Next state plus the output values each state presents during its cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mar_d      = sw_mar;
    dat_d      = sw_dat;
    prog_d     = prog;
    ri_d       = 1'b0;
    in_ready_d = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    aborted_d  = aborted;

    case (state_q)
      S_IDLE: begin
        prog_d = 1'b0;
        if (start) begin
          count_d    = (len == '0 || len > FULL) ? FULL : len;
          mar_d      = '0;
          aborted_d  = 1'b0;
          busy_d     = 1'b1;
          prog_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        prog_d = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_FINISH;
        end else if (in_if.in_valid) begin
          dat_d   = in_if.in_dat;
          state_d = S_SETUP;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        prog_d = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_FINISH;
        end else begin
          ri_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe cycle always completes; abort only stops further words.
        prog_d  = 1'b1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1) || abort) begin
          aborted_d = aborted | abort;
          done_d    = 1'b1;
          state_d   = S_FINISH;
        end else begin
          mar_d      = sw_mar + A'(1);
          in_ready_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FINISH: begin
        prog_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        prog_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Scoreboard bench for ram_program_loader: RAM model, directed scenarios, then randomized sessions.
module tb_ram_program_loader;

  localparam int unsigned N     = 8;
  localparam int unsigned A     = 4;
  localparam int unsigned LW    = A + 1;
  localparam int unsigned DEPTH = 1 << A;

  logic          clk = 1'b0;
  logic          clr, start, abort;
  logic [A:0]    len;
  logic          prog, ri, busy, done, aborted;
  logic [A-1:0]  sw_mar;
  logic [N-1:0]  sw_dat;

  ram_program_loader_if #(.N(N)) in_if ();

  ram_program_loader #(.N(N), .A(A)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .len     (len),
    .in_if   (in_if),
    .abort   (abort),
    .prog    (prog),
    .sw_mar  (sw_mar),
    .sw_dat  (sw_dat),
    .ri      (ri),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           addr;
    logic [N-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [N-1:0] tb_ram  [DEPTH];
  logic [N-1:0] exp_ram [DEPTH];
  logic [N-1:0] words   [DEPTH+1];
  int           n_pass = 0;
  int           n_total = 0;
  int           ri_cnt = 0;
  int           done_cnt = 0;
  logic         prev_ri = 1'b0;
  logic [N-1:0] prev_dat = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Behavioural RAM: captures sw_dat at sw_mar on the edge ending an ri cycle.
  always @(posedge clk) begin
    if (prog && ri) tb_ram[sw_mar] <= sw_dat;
  end

  // Monitor: every write strobe is matched against the next expected (addr, data).
  always @(negedge clk) begin
    if (!clr) begin
      if (ri) begin
        ri_cnt++;
        check("ri_prog", {31'd0, prog}, 32'd1);
        check("ri_single", {31'd0, prev_ri}, 32'd0);
        check("sw_dat_stable", 32'(sw_dat), 32'(prev_dat));
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL write_unexpected: got write mar %0h data %0h, required none", sw_mar, sw_dat);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 32'(sw_mar), 32'(mon_e.addr));
          check("write_data", 32'(sw_dat), 32'(mon_e.data));
        end
      end
      if (done) done_cnt++;
    end
    prev_ri  = ri;
    prev_dat = sw_dat;
  end

  task automatic run_session(input int len_i, input int nw, input int gap, input int abort_idx,
                             input int clr_idx, input int restart_at, input bit start_abort,
                             output int cycles, output int accepted);
    int idx = 0;
    int gapcnt = 0;
    bit abort_done = 1'b0;
    bit fin = 1'b0;
    in_if.in_valid = (nw > 0);
    in_if.in_dat   = words[0];
    start = 1'b1;
    len   = LW'(len_i);
    abort = start_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    cycles = 0;
    while (!fin && cycles < 2000) begin
      @(negedge clk);
      if (done) begin
        check("finish_prog", {31'd0, prog}, 32'd1);
        check("finish_busy", {31'd0, busy}, 32'd1);
        fin = 1'b1;
        break;
      end
      if (clr_idx >= 0 && ri && int'(sw_mar) == clr_idx) begin
        #2 clr = 1'b1;
        #1;
        check("clr_prog", {31'd0, prog}, 32'd0);
        check("clr_ri", {31'd0, ri}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_in_ready", {31'd0, in_if.in_ready}, 32'd0);
        fin = 1'b1;
        break;
      end
      if (abort_idx == idx && in_if.in_ready && !abort_done) begin
        abort = 1'b1;
        abort_done = 1'b1;
      end else if (in_if.in_valid && in_if.in_ready) begin
        exp_q.push_back(exp_t'{addr: idx, data: words[idx]});
        idx++;
        gapcnt = gap;
      end
      @(posedge clk); #1;
      cycles++;
      abort = 1'b0;
      start = (cycles == restart_at);
      if (start) len = LW'(1);
      if (abort_done || idx >= nw) in_if.in_valid = 1'b0;
      else if (gapcnt > 0) begin
        in_if.in_valid = 1'b0;
        gapcnt--;
      end else begin
        in_if.in_valid = 1'b1;
        in_if.in_dat   = words[idx];
      end
    end
    if (!fin) begin
      n_total++;
      $display("FAIL session_timeout: got no done within 2000 cycles, required done");
    end
    start = 1'b0;
    in_if.in_valid = 1'b0;
    accepted = idx;
  endtask

  // Post-session checks one cycle after FINISH, against the bench's own image of RAM.
  task automatic finish_checks(input int exp_w, input int exp_ri, input bit exp_ab,
                               input int r0, input int d0);
    @(posedge clk); #1;
    for (int i = 0; i < exp_w; i++) exp_ram[i] = words[i];
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_prog", {31'd0, prog}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_in_ready", {31'd0, in_if.in_ready}, 32'd0);
    check("aborted_flag", {31'd0, aborted}, {31'd0, exp_ab});
    check("ri_count", 32'(ri_cnt - r0), 32'(exp_ri));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) check("ram_word", 32'(tb_ram[i]), 32'(exp_ram[i]));
  endtask

  initial begin
    int cyc, acc, r0, d0, eff, ab, nwr;
    int lens[6];
    for (int i = 0; i < int'(DEPTH); i++) begin
      tb_ram[i]  = '0;
      exp_ram[i] = '0;
    end
    clr = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    in_if.in_valid = 1'b0; in_if.in_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_prog", {31'd0, prog}, 32'd0);
    check("rst_ri", {31'd0, ri}, 32'd0);
    check("rst_in_ready", {31'd0, in_if.in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_sw_mar", 32'(sw_mar), 32'd0);
    check("rst_sw_dat", 32'(sw_dat), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Three-word program with in_valid held high.
    words[0] = 8'h1E; words[1] = 8'h2F; words[2] = 8'hE0;
    r0 = ri_cnt; d0 = done_cnt;
    run_session(3, 3, 0, -1, -1, -1, 1'b0, cyc, acc);
    check("t1_latency", 32'(cyc), 32'd9);
    finish_checks(3, 3, 1'b0, r0, d0);

    // Sparse source: one word roughly every five clocks.
    words[0] = 8'h5A; words[1] = 8'hC3;
    r0 = ri_cnt; d0 = done_cnt;
    run_session(2, 2, 4, -1, -1, -1, 1'b0, cyc, acc);
    finish_checks(2, 2, 1'b0, r0, d0);

    // len=0 means full depth; a 17th offered word must not be taken.
    for (int i = 0; i <= int'(DEPTH); i++) words[i] = N'(i);
    r0 = ri_cnt; d0 = done_cnt;
    run_session(0, DEPTH + 1, 0, -1, -1, -1, 1'b0, cyc, acc);
    check("t3_accepted", 32'(acc), 32'(DEPTH));
    check("t3_final_mar", 32'(sw_mar), 32'(DEPTH - 1));
    finish_checks(DEPTH, DEPTH, 1'b0, r0, d0);

    // Abort while fetching the third word.
    words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC; words[3] = 8'hDD;
    r0 = ri_cnt; d0 = done_cnt;
    run_session(4, 4, 0, 2, -1, -1, 1'b0, cyc, acc);
    finish_checks(2, 2, 1'b1, r0, d0);

    // start+abort together in IDLE, then start pulsed again mid-session.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    r0 = ri_cnt; d0 = done_cnt;
    run_session(3, 3, 0, -1, -1, 3, 1'b1, cyc, acc);
    finish_checks(3, 3, 1'b0, r0, d0);

    // Reset during the second write strobe.
    words[0] = 8'h55; words[1] = 8'h66; words[2] = 8'h77; words[3] = 8'h88;
    run_session(4, 4, 0, -1, 1, -1, 1'b0, cyc, acc);
    exp_ram[0] = 8'h55;
    check("t5_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    check("t5_sw_mar", 32'(sw_mar), 32'd0);
    check("t5_ram0", 32'(tb_ram[0]), 32'h55);
    check("t5_ram1", 32'(tb_ram[1]), 32'(exp_ram[1]));
    clr = 1'b0;
    @(posedge clk); #1;

    // Randomized sessions: lengths, data, gaps and occasional abort.
    lens = '{0, 17, 1, 16, 7, 20};
    for (int s = 0; s < 6; s++) begin
      if (s >= 2) lens[s] = int'($urandom_range(0, 20));
      eff = (lens[s] == 0 || lens[s] > int'(DEPTH)) ? int'(DEPTH) : lens[s];
      for (int i = 0; i < eff; i++) words[i] = N'($urandom);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, eff - 1)) : -1;
      nwr = (ab >= 0) ? ab : eff;
      r0 = ri_cnt; d0 = done_cnt;
      run_session(lens[s], eff, int'($urandom_range(0, 2)), ab, -1, -1, 1'b0, cyc, acc);
      finish_checks(nwr, nwr, ab >= 0, r0, d0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
